// File: rtl/gb_irq_ctrl.sv
// Parametrised GB interrupt controller: per-source pulse/edge capture, IE/IF registers,
// fixed priority and a two-phase acknowledge that latches the serviced source.
module gb_irq_ctrl #(
    parameter int unsigned             NUM_IRQ    = 5,
    parameter logic [NUM_IRQ-1:0]      SRC_EDGE   = 5'b10001,
    parameter logic [7:0]              VEC_BASE   = 8'h40,
    parameter logic [7:0]              VEC_STRIDE = 8'h08,
    parameter logic [7:0]              NO_VEC     = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               cpu_sel_ie,
    input  logic               cpu_sel_if,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_di,
    output logic [7:0]         cpu_do,
    input  logic               ack,
    output logic               irq_n,
    output logic [7:0]         vector,
    output logic [2:0]         active_idx
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic [NUM_IRQ-1:0]   ie_r;
    logic [NUM_IRQ-1:0]   if_r;
    logic [NUM_IRQ-1:0]   if_nx_s;
    logic [NUM_IRQ-1:0]   src_d_r;
    logic [NUM_IRQ-1:0]   ev_s;
    logic [NUM_IRQ-1:0]   pend_s;
    logic [2:0]           best_s;
    logic                 ack_d_r;
    logic                 ack_rise_s;
    logic                 ack_fall_s;
    logic                 ack_end_s;
    logic                 lat_valid_r;
    logic [2:0]           lat_idx_r;
    logic [7:0]           ie_rd_s;
    logic [7:0]           if_rd_s;

    function automatic logic [7:0] vec_of(input logic [2:0] idx);
        vec_of = VEC_BASE + ({5'b00000, idx} * VEC_STRIDE);
    endfunction

    // Source events, pending set and lowest-index priority pick
    always_comb begin
        ev_s   = (SRC_EDGE & irq_src & ~src_d_r) | (~SRC_EDGE & irq_src);
        pend_s = ie_r & if_r;
        best_s = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_s[i]) begin
                best_s = 3'(i);
            end else begin
                best_s = best_s;
            end
        end
    end

    // Acknowledge edge detection, qualified by the clock enable
    always_comb begin
        ack_rise_s = ce & ack & ~ack_d_r;
        ack_fall_s = ce & ~ack & ack_d_r;
        ack_end_s  = (state_r == ST_ACK) & ack_fall_s;
    end

    // Next IF value: clear < CPU write < new events, so events are never dropped
    always_comb begin
        if_nx_s = if_r;
        if (ack_end_s && lat_valid_r) begin
            if_nx_s[lat_idx_r] = 1'b0;
        end else begin
            if_nx_s = if_r;
        end
        if (cpu_sel_if && cpu_wr) begin
            if_nx_s = cpu_di[NUM_IRQ-1:0];
        end else begin
            if_nx_s = if_nx_s;
        end
        if_nx_s = if_nx_s | ev_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ack_rise_s) state_nx_s = ST_ACK;
                else            state_nx_s = ST_IDLE;
            end
            ST_ACK: begin
                if (ack_fall_s) state_nx_s = ST_IDLE;
                else            state_nx_s = ST_ACK;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Register file, source/ack history and the acknowledge latch
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_r        <= '0;
            if_r        <= '0;
            src_d_r     <= '0;
            ack_d_r     <= 1'b0;
            lat_valid_r <= 1'b0;
            lat_idx_r   <= 3'd0;
        end else if (ce) begin
            src_d_r <= irq_src;
            ack_d_r <= ack;
            if_r    <= if_nx_s;
            if (cpu_sel_ie && cpu_wr) begin
                ie_r <= cpu_di[NUM_IRQ-1:0];
            end
            if ((state_r == ST_IDLE) && ack_rise_s) begin
                lat_valid_r <= |pend_s;
                lat_idx_r   <= best_s;
            end
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        irq_n = ~|pend_s;
        case (state_r)
            ST_IDLE: begin
                vector     = (|pend_s) ? vec_of(best_s) : NO_VEC;
                active_idx = best_s;
            end
            ST_ACK: begin
                vector     = lat_valid_r ? vec_of(lat_idx_r) : NO_VEC;
                active_idx = lat_idx_r;
            end
            default: begin
                vector     = NO_VEC;
                active_idx = 3'd0;
            end
        endcase
    end

    // CPU read mux; unimplemented IE bits read 0, unimplemented IF bits read 1
    always_comb begin
        ie_rd_s                = 8'h00;
        ie_rd_s[NUM_IRQ-1:0]   = ie_r;
        if_rd_s                = 8'hFF;
        if_rd_s[NUM_IRQ-1:0]   = if_r;
        if (cpu_sel_ie) begin
            cpu_do = ie_rd_s;
        end else if (cpu_sel_if) begin
            cpu_do = if_rd_s;
        end else begin
            cpu_do = 8'hFF;
        end
    end

endmodule

// File: doc/gb_irq_ctrl.md
Name: gb_irq_ctrl

Overview:
Parametrised interrupt controller for the GB core. It replaces the fixed 5-source, negedge IE/IF logic with a single-posedge block of NUM_IRQ sources. Each source can be pulse-type or edge-detected, selected per source. A two-phase acknowledge handshake latches the serviced source, so the vector and the bit cleared always match. The block sits between the peripherals (video, timer, serial, joypad, and future CGB sources) and the CPU INT_n/vector path.

Parameters:
NUM_IRQ, 5, number of interrupt sources (1..8); index 0 = highest priority.
SRC_EDGE, 5'b10001, per-source mode: 1 = set IF on rising edge of irq_src[i]; 0 = irq_src[i] is a one-cycle event pulse, set IF while high.
VEC_BASE, 8'h40, vector for source 0.
VEC_STRIDE, 8'h08, vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE, truncated to 8 bits.
NO_VEC, 8'hFF, vector driven when nothing is pending and enabled.

Ports:
clk  in  1  system clock, all state on posedge.
reset  in  1  synchronous, active-high.
ce  in  1  clock enable; all state updates and edge sampling only when ce=1.
irq_src  in  NUM_IRQ  raw interrupt sources.
cpu_sel_ie  in  1  CPU address decodes $FFFF.
cpu_sel_if  in  1  CPU address decodes $FF0F.
cpu_wr  in  1  CPU write strobe (active-high).
cpu_di  in  8  CPU write data.
cpu_do  out  8  register read data.
ack  in  1  CPU acknowledge cycle level (IORQ & M1 active).
irq_n  out  1  active-low interrupt request to CPU.
vector  out  8  interrupt vector for the CPU data bus during ack.
active_idx  out  3  index of the currently latched or serviced source; 0 when none.

Behaviour:
- Registers: ie[NUM_IRQ-1:0] and if_r[NUM_IRQ-1:0]; src_d[NUM_IRQ-1:0] (previous source sample); state; lat_valid; lat_idx[2:0].
- Reset: ie=0, if_r=0, src_d=0, state=IDLE, lat_valid=0, lat_idx=0.
- Reset outputs: irq_n=1, vector=NO_VEC, active_idx=0, cpu_do=8'hFF.
- Reset mid-ack: forces IDLE and discards the latch; no pending bit survives.
- Event detection (ce=1):
  - ev[i] = SRC_EDGE[i] ? (irq_src[i] & ~src_d[i]) : irq_src[i].
  - src_d <= irq_src.
  - Events are registered into if_r at the next posedge, so latency is 1 cycle from source to IF.
- pend = ie & if_r. irq_n = ~|pend, combinational from registers.
- Priority: best = lowest index set in pend.
- State machine:
  - IDLE: vector = pend ? vector(best) : NO_VEC. On ack rising edge (ack=1, ack_d=0): lat_valid <= |pend, lat_idx <= best, go to ACK.
  - ACK: vector = lat_valid ? vector(lat_idx) : NO_VEC, held stable for the whole ack regardless of new events. On ack falling edge: if lat_valid, clear if_r[lat_idx]; go to IDLE.
  - ack_d is a registered copy of ack, updated when ce=1.
- IF update priority within one cycle, lowest to highest:
  1. Hold.
  2. Ack-end clear of lat_idx.
  3. CPU write: if_r <= cpu_di[NUM_IRQ-1:0].
  4. OR in ev.
  - New events are never lost, even when they coincide with a clear or a write.
- IE write: when cpu_sel_ie & cpu_wr & ce, ie <= cpu_di[NUM_IRQ-1:0]. A write during ACK does not change the latched vector.
- Ack with nothing pending: vector=NO_VEC, no bit cleared.
- If the CPU clears the latched bit during ACK, the ack-end clear is harmless; no other bit is cleared.
- Reads (combinational):
  - cpu_sel_ie: {zeros above NUM_IRQ, ie}.
  - cpu_sel_if: {ones above NUM_IRQ, if_r}.
  - Otherwise: 8'hFF.
  - cpu_sel_ie has priority if both selects are active.
- active_idx = lat_idx while in ACK, else best (0 when pend=0).

Test Plan:
- Reset, then set ie=5'h1F and pulse irq_src[2] for 1 cycle (pulse mode) -> if_r=5'h04 next cycle, irq_n=0, vector=8'h50, read $FF0F=8'hE4.
- Set if_r=5'h06 and ie=5'h1F, then ack high for 3 cycles -> vector=8'h48 throughout; after ack falls, if_r=5'h04, vector=8'h50.
- During ACK latched on source 1, raise irq_src[0] (edge mode) -> vector stays 8'h48; after ack falls, if_r[0]=1, if_r[1]=0, and the next vector is 8'h40.
- Ack falling edge on latched bit 3 in the same cycle as a pulse event on source 3 -> if_r[3] remains 1.
- Hold irq_src[0] (edge mode) high for 10 cycles with ie=1, ack once -> exactly one IF set; if_r[0]=0 after ack, irq_n=1.
- Assert reset while ack=1 with lat_idx=2 -> next cycle irq_n=1, vector=8'hFF, if_r=0; ack release clears nothing. Repeat with ce=0 while irq_src toggles -> no IF change.
